fbr_pingpong_buffer: RTL and testbench

//   Feature Buffer Register (FBR) directly downstream of the Haar feature generator.

---
 rtl/fbr_pingpong_buffer_pkg.sv | 37 +++
 rtl/fbr_pingpong_buffer_bank_ram.sv | 43 ++++
 rtl/fbr_pingpong_buffer.sv | 127 ++++++++++++
 tb/tb_fbr_pingpong_buffer.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/fbr_pingpong_buffer_pkg.sv
// Shared widths and bank-occupancy types for the feature buffer register (FBR),
// common to the Haar feature generator, the buffer and the cascade classifier.
package fbr_pingpong_buffer_pkg;

    localparam int FBR_DATA_W = 32;
    localparam int FBR_ADDR_W = 7;
    localparam int FBR_DEPTH  = 128;
    localparam int FBR_WCNT_W = 16;

    // Number of completed banks waiting for the classifier.
    typedef enum logic [1:0] {
        FILL_NONE = 2'd0,
        FILL_ONE  = 2'd1,
        FILL_TWO  = 2'd2
    } fill_e;

    // Handshakes that were actually accepted this cycle.
    typedef struct packed {
        logic wr;
        logic commit;
        logic rel;
        logic rd;
    } fbr_strobes_t;

    // A commit and a release in the same cycle cancel out.
    function automatic fill_e fill_next(input fill_e cur, input logic commit, input logic rel);
        fill_e nxt;
        nxt = cur;
        unique case ({commit, rel})
            2'b10:   nxt = (cur == FILL_NONE) ? FILL_ONE : FILL_TWO;
            2'b01:   nxt = (cur == FILL_TWO) ? FILL_ONE : FILL_NONE;
            default: nxt = cur;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/fbr_pingpong_buffer_bank_ram.sv
// One FBR feature bank: simple dual-port DEPTH x DATA_W RAM with one write port
// and one registered, enable-gated read port whose output holds between reads.
module fbr_pingpong_buffer_bank_ram
    import fbr_pingpong_buffer_pkg::*;
#(
    parameter int DATA_W = FBR_DATA_W,
    parameter int ADDR_W = FBR_ADDR_W,
    parameter int DEPTH  = FBR_DEPTH
) (
    input  logic              iClk,
    input  logic              iReset_n,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    // NOTE: the array has no reset so it maps onto block RAM; readers are gated
    // by the occupancy count, so stale contents are never observed.
    always_ff @(posedge iClk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values, independent of block evaluation order.
    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/fbr_pingpong_buffer.sv
// FBR ping-pong buffer: the generator fills one bank while the classifier
// reads the other; tracks bank ownership, overflow and released windows.
module fbr_pingpong_buffer
    import fbr_pingpong_buffer_pkg::*;
#(
    parameter int DATA_W = FBR_DATA_W,
    parameter int ADDR_W = FBR_ADDR_W,
    parameter int DEPTH  = FBR_DEPTH,
    parameter int WCNT_W = FBR_WCNT_W
) (
    input  logic              iClk,
    input  logic              iReset_n,
    input  logic              iWrreq,
    input  logic [ADDR_W-1:0] iWraddr,
    input  logic [DATA_W-1:0] iFeature,
    input  logic              iFull,
    output logic              oWr_ready,
    output logic              oOverflow,
    output logic              oValid,
    input  logic              iRdreq,
    input  logic [ADDR_W-1:0] iRdaddr,
    output logic [DATA_W-1:0] oRddata,
    output logic              oRdvalid,
    input  logic              iRelease,
    output logic [WCNT_W-1:0] oWin_cnt
);

    fill_e             r_fill;
    logic              r_wr_bank;
    logic              r_rd_bank;
    logic              r_rd_sel;
    logic              r_rdvalid;
    logic              r_overflow;
    logic [WCNT_W-1:0] r_win_cnt;

    logic              w_wr_ready;
    logic              w_valid;
    logic              w_drop;
    fbr_strobes_t      w_acc;
    logic [DATA_W-1:0] w_bank_rdata [2];

    // Ready is decoded from the registered count only; a release in the same
    // cycle does not make room for a commit until the following cycle.
    assign w_wr_ready = (r_fill != FILL_TWO);
    assign w_valid    = (r_fill != FILL_NONE);
    assign w_drop     = (iWrreq | iFull) & ~w_wr_ready;

    assign w_acc = '{
        wr:     iWrreq   & w_wr_ready,
        commit: iFull    & w_wr_ready,
        rel:    iRelease & w_valid,
        rd:     iRdreq   & w_valid
    };

    for (genvar b = 0; b < 2; b++) begin : g_bank
        fbr_pingpong_buffer_bank_ram #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W),
            .DEPTH  (DEPTH)
        ) u_bank (
            .iClk     (iClk),
            .iReset_n (iReset_n),
            .i_we     (w_acc.wr && (r_wr_bank == 1'(b))),
            .i_waddr  (iWraddr),
            .i_wdata  (iFeature),
            .i_re     (w_acc.rd && (r_rd_bank == 1'(b))),
            .i_raddr  (iRdaddr),
            .o_rdata  (w_bank_rdata[b])
        );
    end

    // Bank ownership and occupancy.
    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            r_fill    <= FILL_NONE;
            r_wr_bank <= 1'b0;
            r_rd_bank <= 1'b0;
        end else begin
            r_fill <= fill_next(r_fill, w_acc.commit, w_acc.rel);
            if (w_acc.commit) begin
                r_wr_bank <= ~r_wr_bank;
            end
            if (w_acc.rel) begin
                r_rd_bank <= ~r_rd_bank;
            end
        end
    end

    // Read qualifier and the bank select that steers the held read data.
    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            r_rdvalid <= 1'b0;
            r_rd_sel  <= 1'b0;
        end else begin
            r_rdvalid <= w_acc.rd;
            if (w_acc.rd) begin
                r_rd_sel <= r_rd_bank;
            end
        end
    end

    // Sticky overflow flag and released-window counter (wraps naturally).
    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            r_overflow <= 1'b0;
            r_win_cnt  <= '0;
        end else begin
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            if (w_acc.rel) begin
                r_win_cnt <= r_win_cnt + 1'b1;
            end
        end
    end

    assign oWr_ready = w_wr_ready;
    assign oValid    = w_valid;
    assign oOverflow = r_overflow;
    assign oRdvalid  = r_rdvalid;
    assign oRddata   = w_bank_rdata[r_rd_sel];
    assign oWin_cnt  = r_win_cnt;

    a_bank_exclusive: assert property (@(posedge iClk) disable iff (!iReset_n)
        (r_fill == FILL_ONE) |-> (r_wr_bank != r_rd_bank));

endmodule

// File: tb/tb_fbr_pingpong_buffer.sv
// Self-checking bench for fbr_pingpong_buffer: read data goes through a scoreboard
// queue, control behaviour through a vector table plus hand-written sequences.
module tb_fbr_pingpong_buffer;

    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    logic        iClk = 1'b0;
    logic        iReset_n;
    logic        iWrreq;
    logic [6:0]  iWraddr;
    logic [31:0] iFeature;
    logic        iFull;
    logic        oWr_ready;
    logic        oOverflow;
    logic        oValid;
    logic        iRdreq;
    logic [6:0]  iRdaddr;
    logic [31:0] oRddata;
    logic        oRdvalid;
    logic        iRelease;
    logic [15:0] oWin_cnt;

    int          n_vec  = 0;
    int          n_fail = 0;
    logic [31:0] sb [$];

    typedef struct {
        logic        wr;
        logic [6:0]  wa;
        logic [31:0] d;
        logic        full;
        logic        rd;
        logic [6:0]  ra;
        logic        rel;
        logic        erd;
        logic [31:0] edata;
        logic        ewr;
        logic        evalid;
        logic        eovf;
        logic [15:0] ewcnt;
    } vec_t;

    vec_t tbl [19];

    always #5 iClk = ~iClk;

    fbr_pingpong_buffer dut (
        .iClk      (iClk),
        .iReset_n  (iReset_n),
        .iWrreq    (iWrreq),
        .iWraddr   (iWraddr),
        .iFeature  (iFeature),
        .iFull     (iFull),
        .oWr_ready (oWr_ready),
        .oOverflow (oOverflow),
        .oValid    (oValid),
        .iRdreq    (iRdreq),
        .iRdaddr   (iRdaddr),
        .oRddata   (oRddata),
        .oRdvalid  (oRdvalid),
        .iRelease  (iRelease),
        .oWin_cnt  (oWin_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Every returned read word must match the oldest outstanding expectation.
    always @(negedge iClk) begin
        if (iReset_n === 1'b1 && oRdvalid === 1'b1) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL rd_unexpected: got oRdvalid=1 data 0x%0h, want no read data", oRddata);
            end else begin
                check("rd_data", oRddata, sb.pop_front());
            end
        end
    end

    // Drive one cycle of inputs at the falling edge, return at the next falling edge.
    task automatic cyc(input logic wr, input logic [6:0] wa, input logic [31:0] d,
                       input logic full, input logic rd, input logic [6:0] ra,
                       input logic rel, input logic erd, input logic [31:0] ed);
        iWrreq   = wr;
        iWraddr  = wa;
        iFeature = d;
        iFull    = full;
        iRdreq   = rd;
        iRdaddr  = ra;
        iRelease = rel;
        if (erd) sb.push_back(ed);
        @(posedge iClk);
        @(negedge iClk);
    endtask

    function automatic vec_t mk(input logic wr, input logic [6:0] wa, input logic [31:0] d,
                                input logic full, input logic rd, input logic [6:0] ra,
                                input logic rel, input logic erd, input logic [31:0] edata,
                                input logic ewr, input logic evalid, input logic eovf,
                                input logic [15:0] ewcnt);
        vec_t v;
        v = '{wr, wa, d, full, rd, ra, rel, erd, edata, ewr, evalid, eovf, ewcnt};
        return v;
    endfunction

    initial begin
        // Starts with bank0 = 0x100+a pending, bank1 = 0x200+a pending, wr=0 rd=0.
        tbl[0]  = mk(H, 7'd3,   32'hDEAD, L, L, 7'd0,   L, L, 32'h0,   L, H, H, 16'd0);
        tbl[1]  = mk(L, 7'd0,   32'h0,    H, L, 7'd0,   L, L, 32'h0,   L, H, H, 16'd0);
        tbl[2]  = mk(L, 7'd0,   32'h0,    L, H, 7'd3,   L, H, 32'h103, L, H, H, 16'd0);
        tbl[3]  = mk(L, 7'd0,   32'h0,    L, H, 7'd4,   H, H, 32'h104, H, H, H, 16'd1);
        tbl[4]  = mk(L, 7'd0,   32'h0,    L, H, 7'd3,   L, H, 32'h203, H, H, H, 16'd1);
        tbl[5]  = mk(H, 7'd0,   32'h300,  L, L, 7'd0,   L, L, 32'h0,   H, H, H, 16'd1);
        tbl[6]  = mk(H, 7'd1,   32'h301,  L, L, 7'd0,   L, L, 32'h0,   H, H, H, 16'd1);
        tbl[7]  = mk(H, 7'd2,   32'h302,  H, H, 7'd2,   H, H, 32'h202, H, H, H, 16'd2);
        tbl[8]  = mk(L, 7'd0,   32'h0,    L, H, 7'd2,   L, H, 32'h302, H, H, H, 16'd2);
        tbl[9]  = mk(L, 7'd0,   32'h0,    L, H, 7'd1,   L, H, 32'h301, H, H, H, 16'd2);
        tbl[10] = mk(L, 7'd0,   32'h0,    L, H, 7'd100, L, H, 32'h164, H, H, H, 16'd2);
        tbl[11] = mk(L, 7'd0,   32'h0,    L, L, 7'd0,   H, L, 32'h0,   H, L, H, 16'd3);
        tbl[12] = mk(L, 7'd0,   32'h0,    L, H, 7'd5,   H, L, 32'h0,   H, L, H, 16'd3);
        tbl[13] = mk(L, 7'd0,   32'h0,    L, L, 7'd0,   L, L, 32'h0,   H, L, H, 16'd3);
        tbl[14] = mk(H, 7'd7,   32'h407,  H, L, 7'd0,   L, L, 32'h0,   H, H, H, 16'd3);
        tbl[15] = mk(H, 7'd7,   32'h507,  H, L, 7'd0,   L, L, 32'h0,   L, H, H, 16'd3);
        tbl[16] = mk(H, 7'd7,   32'h607,  H, L, 7'd0,   H, L, 32'h0,   H, H, H, 16'd4);
        tbl[17] = mk(L, 7'd0,   32'h0,    L, H, 7'd7,   L, H, 32'h507, H, H, H, 16'd4);
        tbl[18] = mk(L, 7'd0,   32'h0,    L, L, 7'd0,   H, L, 32'h0,   H, L, H, 16'd5);

        iReset_n = 1'b0;
        iWrreq = 1'b0; iWraddr = '0; iFeature = '0; iFull = 1'b0;
        iRdreq = 1'b0; iRdaddr = '0; iRelease = 1'b0;
        repeat (2) @(negedge iClk);
        iReset_n = 1'b1;

        // Reset state.
        check("rst_wr_ready", 32'(oWr_ready), 32'd1);
        check("rst_valid",    32'(oValid),    32'd0);
        check("rst_overflow", 32'(oOverflow), 32'd0);
        check("rst_win_cnt",  32'(oWin_cnt),  32'd0);
        check("rst_rdvalid",  32'(oRdvalid),  32'd0);
        check("rst_rddata",   oRddata,        32'd0);

        // Fill bank0, commit on the last write, then read one word back.
        for (int a = 0; a < 128; a++) begin
            cyc(H, 7'(a), 32'(a + 'h100), (a == 127), L, 7'd0, L, L, 32'h0);
            if (a == 126) check("fill_valid_early", 32'(oValid), 32'd0);
        end
        check("commit_valid",    32'(oValid),    32'd1);
        check("commit_wr_ready", 32'(oWr_ready), 32'd1);
        cyc(L, 7'd0, 32'h0, L, H, 7'd5, L, H, 32'h105);
        check("rdvalid_pulse", 32'(oRdvalid), 32'd1);
        cyc(L, 7'd0, 32'h0, L, L, 7'd0, L, L, 32'h0);
        check("rdvalid_drop", 32'(oRdvalid), 32'd0);
        check("rddata_hold",  oRddata,       32'h105);

        // Fill bank1 so both banks are pending.
        for (int a = 0; a < 128; a++) begin
            cyc(H, 7'(a), 32'(a + 'h200), (a == 127), L, 7'd0, L, L, 32'h0);
        end
        check("both_full_wr_ready", 32'(oWr_ready), 32'd0);
        check("both_full_valid",    32'(oValid),    32'd1);

        for (int k = 0; k < 19; k++) begin
            vec_t v;
            v = tbl[k];
            cyc(v.wr, v.wa, v.d, v.full, v.rd, v.ra, v.rel, v.erd, v.edata);
            check($sformatf("row%0d_wr_ready", k), 32'(oWr_ready), 32'(v.ewr));
            check($sformatf("row%0d_valid", k),    32'(oValid),    32'(v.evalid));
            check($sformatf("row%0d_overflow", k), 32'(oOverflow), 32'(v.eovf));
            check($sformatf("row%0d_win_cnt", k),  32'(oWin_cnt),  32'(v.ewcnt));
            check($sformatf("row%0d_rdvalid", k),  32'(oRdvalid),  32'(v.erd));
        end

        // Asynchronous reset mid-fill with one complete bank pending.
        cyc(H, 7'd0, 32'h7000, H, L, 7'd0, L, L, 32'h0);
        for (int a = 0; a < 60; a++) begin
            cyc(H, 7'(a), 32'(a + 'h8000), L, L, 7'd0, L, L, 32'h0);
        end
        check("prerst_valid", 32'(oValid), 32'd1);
        iWrreq = 1'b1; iWraddr = 7'd60; iFeature = 32'h803c;
        #2 iReset_n = 1'b0;
        #1;
        check("midrst_valid",    32'(oValid),    32'd0);
        check("midrst_wr_ready", 32'(oWr_ready), 32'd1);
        check("midrst_overflow", 32'(oOverflow), 32'd0);
        check("midrst_win_cnt",  32'(oWin_cnt),  32'd0);
        check("midrst_rddata",   oRddata,        32'd0);
        @(negedge iClk);
        iWrreq = 1'b0; iWraddr = '0; iFeature = '0;
        @(negedge iClk);
        iReset_n = 1'b1;
        cyc(L, 7'd0, 32'h0, L, H, 7'd0, H, L, 32'h0);
        check("postrst_rdvalid", 32'(oRdvalid), 32'd0);
        check("postrst_win_cnt", 32'(oWin_cnt), 32'd0);

        // One-word windows, committed and released every cycle, until the counter wraps.
        cyc(H, 7'd0, 32'h0, H, L, 7'd0, L, L, 32'h0);
        for (int i = 1; i < 65536; i++) begin
            cyc(H, 7'd0, 32'(i), H, H, 7'd0, H, H, 32'(i - 1));
            if (i == 1)     check("wrap_first_cnt", 32'(oWin_cnt), 32'd1);
            if (i == 65535) check("wrap_max_cnt",   32'(oWin_cnt), 32'h0000_ffff);
        end
        check("wrap_valid_steady", 32'(oValid), 32'd1);
        cyc(L, 7'd0, 32'h0, L, H, 7'd0, H, H, 32'd65535);
        check("wrap_zero_cnt", 32'(oWin_cnt), 32'd0);
        check("wrap_valid",    32'(oValid),   32'd0);
        cyc(L, 7'd0, 32'h0, L, L, 7'd0, L, L, 32'h0);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
